// File: rtl/freeze_ctrl.sv
// freeze_ctrl: pipeline-wide run enable for the LC-3b pipelined core.
// Merges NUM_PORTS memory handshakes, sequences the two accesses of
// LDI/STI, and provides debug halt, a stall-cycle counter and a sticky
// stall-timeout watchdog.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IND_IDLE   | no indirect in flight, or LDI/STI on its first access
// IND_SECOND | LDI/STI second (final) access in progress
module freeze_ctrl #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_PORT = 1,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] port_req,
    input  logic [NUM_PORTS-1:0] port_resp,
    input  logic                 indirect,
    input  logic                 debug_halt,
    input  logic                 perf_clr,
    output logic                 run,
    output logic [NUM_PORTS-1:0] stall_vec,
    output logic                 indirect_phase,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic                 timeout_err
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IND_IDLE   = 1'b0,
        IND_SECOND = 1'b1
    } ind_state_e;

    ind_state_e state_q, state_d;

    logic mem_stall;
    logic ind_hold;
    logic first_done;

    assign stall_vec  = port_req & ~port_resp;
    assign mem_stall  = |stall_vec;
    assign ind_hold   = indirect & (state_q == IND_IDLE);
    assign run        = ~rst & ~debug_halt & ~mem_stall & ~ind_hold;
    assign first_done = port_resp[DATA_PORT] | ~port_req[DATA_PORT];

    assign indirect_phase = (state_q == IND_SECOND);

    // Next-state logic; a halted or stalled pipeline never advances the FSM,
    // so a response seen under debug_halt is left for the memory to re-present.
    always_comb begin
        state_d = state_q;
        if (!debug_halt && !mem_stall) begin
            case (state_q)
                IND_IDLE: begin
                    if (indirect && first_done) begin
                        state_d = IND_SECOND;
                    end
                end
                IND_SECOND: begin
                    if (run || !indirect) begin
                        state_d = IND_IDLE;
                    end
                end
                default: state_d = IND_IDLE;
            endcase
        end
    end

    // Indirect-sequencing state register; reset restarts LDI/STI from access one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IND_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // Saturating stall-cycle counter; clear wins over increment.
    always_comb begin
        stall_count_d = stall_count_q;
        if (perf_clr) begin
            stall_count_d = '0;
        end else if (!run && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

            logic [WD_W-1:0] wd_q, wd_d;
            logic            err_q, err_d;

            // Consecutive-stall count; halt cycles freeze it, any run cycle clears it.
            always_comb begin
                wd_d = wd_q;
                if (run) begin
                    wd_d = '0;
                end else if (!debug_halt && (wd_q != WD_LIMIT)) begin
                    wd_d = wd_q + WD_W'(1);
                end
                err_d = err_q | (wd_d == WD_LIMIT);
            end

            // Watchdog registers; the error flag is sticky until reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wd_q  <= '0;
                    err_q <= 1'b0;
                end else begin
                    wd_q  <= wd_d;
                    err_q <= err_d;
                end
            end

            assign timeout_err = err_q;
        end else begin : g_no_wd
            assign timeout_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_freeze_ctrl.sv
// Scoreboard bench for freeze_ctrl: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
// dut_a: CNT_WIDTH=4, TIMEOUT=8. dut_b: CNT_WIDTH=16, TIMEOUT=0 (same inputs).
module tb_freeze_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] port_req;
    logic [1:0] port_resp;
    logic       indirect;
    logic       debug_halt;
    logic       perf_clr;

    logic        run_a, run_b;
    logic [1:0]  sv_a, sv_b;
    logic        ph_a, ph_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    logic        err_a, err_b;

    freeze_ctrl #(.NUM_PORTS(2), .DATA_PORT(1), .CNT_WIDTH(4), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .port_req(port_req), .port_resp(port_resp),
        .indirect(indirect), .debug_halt(debug_halt), .perf_clr(perf_clr),
        .run(run_a), .stall_vec(sv_a), .indirect_phase(ph_a),
        .stall_count(cnt_a), .timeout_err(err_a)
    );

    freeze_ctrl #(.NUM_PORTS(2), .DATA_PORT(1), .CNT_WIDTH(16), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .port_req(port_req), .port_resp(port_resp),
        .indirect(indirect), .debug_halt(debug_halt), .perf_clr(perf_clr),
        .run(run_b), .stall_vec(sv_b), .indirect_phase(ph_b),
        .stall_count(cnt_b), .timeout_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {K_RUN, K_SV, K_PH, K_CNT, K_ERR, K_CNTB, K_ERRB} kind_e;
    typedef struct {
        kind_e kind;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_v(input kind_e k, input int v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] rp,
                         input logic ind, input logic hlt, input logic clr);
        @(posedge clk);
        #1;
        port_req   = rq;
        port_resp  = rp;
        indirect   = ind;
        debug_halt = hlt;
        perf_clr   = clr;
    endtask

    // Monitor: every cycle, compare all expectations queued for that cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            int   act;
            e = sb.pop_front();
            case (e.kind)
                K_RUN:   act = int'(run_a);
                K_SV:    act = int'(sv_a);
                K_PH:    act = int'(ph_a);
                K_CNT:   act = int'(cnt_a);
                K_ERR:   act = int'(err_a);
                K_CNTB:  act = int'(cnt_b);
                default: act = int'(err_b);
            endcase
            n_checks++;
            if (act == e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        port_req   = 2'b01;
        port_resp  = 2'b01;
        indirect   = 1'b0;
        debug_halt = 1'b0;
        perf_clr   = 1'b0;

        // reset state
        drive(2'b01, 2'b01, 0, 0, 0);
        expect_v(K_RUN, 0, "rst_run");
        expect_v(K_CNT, 0, "rst_cnt");
        expect_v(K_ERR, 0, "rst_err");
        expect_v(K_PH,  0, "rst_phase");

        drive(2'b01, 2'b01, 0, 0, 0);
        rst = 1'b0;
        expect_v(K_RUN, 1, "rel_run");
        expect_v(K_SV,  0, "rel_sv");
        expect_v(K_CNT, 0, "rel_cnt");
        expect_v(K_ERR, 0, "rel_err");

        // fetch miss for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 2'b00, 0, 0, 0);
            expect_v(K_RUN, 0, "fmiss_run");
            expect_v(K_SV,  1, "fmiss_sv");
            expect_v(K_CNT, i, "fmiss_cnt");
        end
        drive(2'b01, 2'b01, 0, 0, 0);
        expect_v(K_RUN,  1, "fmiss_done_run");
        expect_v(K_CNT,  5, "fmiss_cnt5");
        expect_v(K_CNTB, 5, "fmiss_cnt5_b");

        drive(2'b01, 2'b01, 0, 0, 1);
        expect_v(K_CNT, 5, "clr_cycle_cnt");

        // LDI: 3 wait cycles, first resp, 2 wait cycles, second resp
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b01, 1, 0, 0);
            expect_v(K_RUN, 0, "ldi1_run");
            expect_v(K_SV,  2, "ldi1_sv");
            expect_v(K_PH,  0, "ldi1_phase");
            if (i == 0) expect_v(K_CNT, 0, "ldi_cnt_start");
        end
        drive(2'b11, 2'b11, 1, 0, 0);
        expect_v(K_RUN, 0, "ldi1_resp_run");
        expect_v(K_SV,  0, "ldi1_resp_sv");
        expect_v(K_PH,  0, "ldi1_resp_phase");
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 2'b01, 1, 0, 0);
            expect_v(K_RUN, 0, "ldi2_run");
            expect_v(K_PH,  1, "ldi2_phase");
        end
        drive(2'b11, 2'b11, 1, 0, 0);
        expect_v(K_RUN, 1, "ldi_commit_run");
        expect_v(K_PH,  1, "ldi_commit_phase");
        drive(2'b01, 2'b01, 0, 0, 0);
        expect_v(K_RUN, 1, "ldi_after_run");
        expect_v(K_PH,  0, "ldi_after_phase");
        expect_v(K_CNT, 6, "ldi_total_cnt");

        // reset while in IND_SECOND
        drive(2'b11, 2'b11, 1, 0, 0);
        expect_v(K_RUN, 0, "rs_first_run");
        drive(2'b11, 2'b01, 1, 0, 0);
        expect_v(K_PH,  1, "rs_second_phase");
        drive(2'b11, 2'b01, 1, 0, 0);
        rst = 1'b1;
        expect_v(K_PH,  0, "rs_async_phase");
        expect_v(K_RUN, 0, "rs_async_run");
        expect_v(K_CNT, 0, "rs_async_cnt");
        drive(2'b11, 2'b11, 1, 0, 0);
        rst = 1'b0;
        expect_v(K_RUN, 0, "rs_repeat_run");
        expect_v(K_PH,  0, "rs_repeat_phase");
        drive(2'b11, 2'b11, 1, 0, 0);
        expect_v(K_RUN, 1, "rs_commit_run");
        expect_v(K_PH,  1, "rs_commit_phase");
        expect_v(K_CNT, 1, "rs_commit_cnt");
        drive(2'b01, 2'b01, 0, 0, 0);
        expect_v(K_PH,  0, "rs_after_phase");

        // watchdog: 4 stalls, 2 halted stalls (not counted), 5 more stalls
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b01, 0, 0, 0);
            expect_v(K_RUN, 0, "wd_run");
            expect_v(K_SV,  2, "wd_sv");
            expect_v(K_ERR, 0, "wd_err_early");
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 2'b01, 0, 1, 0);
            expect_v(K_RUN, 0, "wd_halt_run");
            expect_v(K_ERR, 0, "wd_halt_err");
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b01, 0, 0, 0);
            expect_v(K_ERR, 0, "wd_err_before_limit");
        end
        drive(2'b11, 2'b01, 0, 0, 0);
        expect_v(K_ERR,  1, "wd_err_set");
        expect_v(K_ERRB, 0, "wd_disabled_err_b");
        drive(2'b11, 2'b11, 0, 0, 0);
        expect_v(K_RUN, 1, "wd_resp_run");
        expect_v(K_ERR, 1, "wd_sticky_resp");
        drive(2'b01, 2'b01, 0, 0, 1);
        expect_v(K_ERR, 1, "wd_sticky_clr_cycle");
        drive(2'b01, 2'b01, 0, 0, 0);
        expect_v(K_ERR,  1, "wd_sticky_after_clr");
        expect_v(K_CNT,  0, "wd_clr_cnt");
        expect_v(K_CNTB, 0, "wd_clr_cnt_b");

        // saturation: 20 stalled cycles, then clear during stall
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, 2'b00, 0, 0, 0);
            if (i == 15) expect_v(K_CNT, 15, "sat_reach");
            if (i == 16) begin
                expect_v(K_CNT,  15, "sat_no_wrap");
                expect_v(K_CNTB, 16, "wide_cnt_b");
            end
        end
        drive(2'b01, 2'b00, 0, 0, 1);
        expect_v(K_CNT,  15, "sat_hold20");
        expect_v(K_CNTB, 20, "wide_cnt20_b");
        drive(2'b01, 2'b00, 0, 0, 0);
        expect_v(K_RUN,  0, "clr_stall_run");
        expect_v(K_CNT,  0, "clr_stall_zero");
        expect_v(K_CNTB, 0, "clr_stall_zero_b");
        drive(2'b01, 2'b00, 0, 0, 0);
        expect_v(K_CNT,  1, "clr_stall_one");
        drive(2'b01, 2'b01, 0, 0, 0);
        expect_v(K_ERR,  1, "sat_err_sticky");

        // only reset clears the watchdog flag
        drive(2'b01, 2'b01, 0, 0, 0);
        rst = 1'b1;
        expect_v(K_ERR, 0, "rst_clears_err");
        drive(2'b01, 2'b01, 0, 0, 0);
        rst = 1'b0;
        expect_v(K_RUN, 1, "final_run");

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freeze_ctrl.md
Name: freeze_ctrl

Overview:
- Parametrised pipeline freeze controller for the LC-3b pipelined core.
- Combines the memory handshakes of NUM_PORTS memory ports into a single pipeline-wide run enable. Port 0 is instruction fetch; port DATA_PORT is the MEM-stage data port.
- Owns the LDI/STI two-access sequencing internally with a small FSM, so the datapath no longer supplies a phase signal.
- Adds a debug halt, a saturating stall-cycle performance counter and a sticky stall-timeout watchdog.

Parameters:
- NUM_PORTS, 2, number of memory ports (>=2); port 0 = instruction fetch.
- DATA_PORT, 1, index of the data port used by LDI/STI (1..NUM_PORTS-1).
- CNT_WIDTH, 16, width of the stall-cycle counter.
- TIMEOUT, 1024, consecutive stalled cycles before timeout_err sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- port_req  in  NUM_PORTS  per-port access in progress (read|write); fetch drives bit 0 high every cycle it fetches.
- port_resp  in  NUM_PORTS  per-port memory response, valid the cycle the access completes.
- indirect  in  1  MEM stage holds an LDI or STI.
- debug_halt  in  1  level-sensitive external freeze request.
- perf_clr  in  1  synchronous clear of stall_count.
- run  out  1  pipeline advance enable (combinational).
- stall_vec  out  NUM_PORTS  per-port stall cause (combinational).
- indirect_phase  out  1  registered; 1 = LDI/STI second (final) access in progress; steers the address mux.
- stall_count  out  CNT_WIDTH  saturating count of cycles with run=0.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- stall_vec[i] = port_req[i] & ~port_resp[i].
- mem_stall = OR of stall_vec.
- FSM states: IND_IDLE, IND_SECOND. indirect_phase = (state==IND_SECOND).
- ind_hold = indirect & (state==IND_IDLE). An LDI/STI is never committed on its first access.
- run = ~rst & ~debug_halt & ~mem_stall & ~ind_hold.
- Transitions evaluate only when ~debug_halt & ~mem_stall; otherwise the state holds.
  - IND_IDLE -> IND_SECOND when indirect=1 and the first data access completes (port_resp[DATA_PORT]=1 or port_req[DATA_PORT]=0). run=0 that cycle.
  - IND_SECOND -> IND_IDLE when run=1, i.e. the second access completes and the instruction commits.
  - IND_SECOND with indirect=0 (flush) -> IND_IDLE next cycle.
- stall_count:
  - increments by 1 each cycle run=0, saturating at all-ones with no wrap.
  - perf_clr has priority: the counter loads 0 that cycle, even if stalled.
  - Cycles with rst asserted are not counted.
- Watchdog:
  - an internal consecutive-stall counter, sized clog2(TIMEOUT+1) bits, increments while run=0 and resets to 0 on any cycle with run=1.
  - debug_halt cycles do not count; the watchdog counter holds during them.
  - On reaching TIMEOUT, timeout_err sets and stays set until rst. perf_clr does not clear it.
  - TIMEOUT=0: timeout_err is constant 0.
- Reset values: state=IND_IDLE, indirect_phase=0, stall_count=0, watchdog=0, timeout_err=0, run=0 while rst=1.
- Reset mid-LDI/STI: the FSM returns to IND_IDLE immediately (async); the instruction restarts from its first access.
- Simultaneous events:
  - fetch stall and data stall together: both bits set in stall_vec, run=0.
  - debug_halt with a response arriving: the response is not consumed by the FSM. Memories are required to hold resp until run=1.
- No combinational path from any registered output back into the FSM inputs.

Test Plan:
- Reset release with port_req=2'b01, port_resp=2'b01, indirect=0 -> run=1 on the first cycle after rst deasserts; stall_count=0; timeout_err=0.
- Fetch miss: port_resp[0]=0 for 5 cycles, then 1 -> run=0 for 5 cycles, stall_vec=2'b01, stall_count=5, then run=1.
- LDI with indirect=1:
  - data resp after 3 cycles -> state to IND_SECOND, indirect_phase=1, run=0 throughout.
  - second resp after 2 more cycles -> run=1 for one cycle, then indirect_phase=0.
  - Total stall_count=6.
- Reset asserted during IND_SECOND -> indirect_phase=0 immediately; after release with indirect=1, the first access repeats (run=0 until two responses are seen).
- TIMEOUT=8 with port_resp[1]=0 held and port_req[1]=1 -> timeout_err=1 after 8 stalled cycles and stays 1 after resp returns and after perf_clr; only rst clears it.
- CNT_WIDTH=4: 20 stalled cycles -> stall_count saturates at 15. Then perf_clr during a stall -> 0 that cycle, 1 the next cycle.
